// File: rtl/md_issue_ctrl.sv
// EX-stage initiator for the HI/LO multiply/divide unit: issues a registered start,
// tracks unit occupancy, stalls dependent MD/MF ops and returns HI/LO for mfhi/mflo.
module md_issue_ctrl #(
   parameter int unsigned WATCHDOG = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [3:0]  ex_op,
   input  logic [31:0] ex_rs,
   input  logic [31:0] ex_rt,
   input  logic        flush,
   input  logic        md_busy,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic        md_start,
   output logic [31:0] md_A,
   output logic [31:0] md_B,
   output logic [2:0]  md_ctrl,
   output logic        stall,
   output logic [31:0] mf_data,
   output logic        md_timeout
);

   // state | meaning
   // IDLE  | no op owned by this block; new MD op may be accepted
   // ISSUE | start is high this cycle; unit has not yet raised busy
   // BUSY  | compute op running; watchdog counts busy cycles
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;

   localparam logic [2:0] MT_MULTIPLY          = 3'd1;
   localparam logic [2:0] MT_MULTIPLY_UNSIGNED = 3'd2;
   localparam logic [2:0] MT_DIVIDE            = 3'd3;
   localparam logic [2:0] MT_DIVIDE_UNSIGNED   = 3'd4;
   localparam logic [2:0] MT_SET_HI            = 3'd5;
   localparam logic [2:0] MT_SET_LO            = 3'd6;

   localparam int unsigned WDW = $clog2(WATCHDOG + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(WATCHDOG - 1);

   state_e         state_q;
   logic [WDW-1:0] wdog_q;
   logic           hazard;
   logic           is_md;
   logic           accept;
   logic [2:0]     ctrl_d;

   always_comb begin
      hazard  = ex_valid & ~flush & (ex_op >= 4'd1) & (ex_op <= 4'd8);
      is_md   = (ex_op >= 4'd1) & (ex_op <= 4'd6);
      // A finished op in BUSY with busy already low does not hold EX
      stall   = hazard & ((state_q == S_ISSUE) |
                          ((state_q == S_BUSY) & md_busy) |
                          ((state_q == S_IDLE) & md_busy));
      accept  = hazard & ~stall & is_md;
      ctrl_d  = 3'd0;
      unique case (ex_op)
         4'd1:    ctrl_d = MT_MULTIPLY;
         4'd2:    ctrl_d = MT_MULTIPLY_UNSIGNED;
         4'd3:    ctrl_d = MT_DIVIDE;
         4'd4:    ctrl_d = MT_DIVIDE_UNSIGNED;
         4'd5:    ctrl_d = MT_SET_HI;
         4'd6:    ctrl_d = MT_SET_LO;
         default: ctrl_d = 3'd0;
      endcase
      mf_data = 32'h0;
      if (ex_op == 4'd7) mf_data = md_hi;
      else if (ex_op == 4'd8) mf_data = md_lo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         md_start   <= 1'b0;
         md_A       <= 32'h0;
         md_B       <= 32'h0;
         md_ctrl    <= 3'd0;
         md_timeout <= 1'b0;
         wdog_q     <= '0;
      end else begin
         md_start <= 1'b0;
         if (accept) begin
            md_A     <= ex_rs;
            md_B     <= ex_rt;
            md_ctrl  <= ctrl_d;
            md_start <= 1'b1;
         end
         unique case (state_q)
            S_IDLE: begin
               if (accept) state_q <= S_ISSUE;
            end
            S_ISSUE: begin
               wdog_q  <= '0;
               state_q <= (md_ctrl <= MT_DIVIDE_UNSIGNED) ? S_BUSY : S_IDLE;
            end
            S_BUSY: begin
               if (!md_busy) begin
                  state_q <= accept ? S_ISSUE : S_IDLE;
               end else if (wdog_q == WD_LAST) begin
                  state_q    <= S_IDLE;
                  md_timeout <= 1'b1;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: a behavioural MD unit plus an architectural HI/LO and
// occupancy model checked every cycle, with directed literal scenarios and random traffic.
module tb_md_issue_ctrl;

   localparam int WATCHDOG = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid = 1'b0;
   logic [3:0]  ex_op = 4'd0;
   logic [31:0] ex_rs = 32'h0;
   logic [31:0] ex_rt = 32'h0;
   logic        flush = 1'b0;
   logic        md_busy;
   logic [31:0] md_hi, md_lo;
   logic        md_start, stall, md_timeout;
   logic [31:0] md_A, md_B, mf_data;
   logic [2:0]  md_ctrl;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;
   bit stuck_req = 1'b0;

   always #5 clk = ~clk;

   md_issue_ctrl #(.WATCHDOG(WATCHDOG)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .md_busy(md_busy),
      .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start), .md_A(md_A),
      .md_B(md_B), .md_ctrl(md_ctrl), .stall(stall), .mf_data(mf_data),
      .md_timeout(md_timeout)
   );

   // {defined, hi, lo} for compute ops 1..4
   function automatic logic [64:0] md_result(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] p;
      logic [31:0] q, r;
      md_result = {1'b0, 64'h0};
      case (c)
         3'd1: begin
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            md_result = {1'b1, p};
         end
         3'd2: begin
            p = {32'h0, a} * {32'h0, b};
            md_result = {1'b1, p};
         end
         3'd3: begin
            if (b != 32'h0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               md_result = {1'b1, r, q};
            end
         end
         3'd4: begin
            if (b != 32'h0) md_result = {1'b1, a % b, a / b};
         end
         default: md_result = {1'b0, 64'h0};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural unit: mult busy 5 cycles, div 10, or 20 when stuck_req is set
   logic [64:0] u_res;
   logic [31:0] u_hi, u_lo;
   int          u_cnt;
   assign u_res = md_result(md_ctrl, md_A, md_B);

   always @(posedge clk) begin
      if (reset) begin
         md_busy <= 1'b0; u_cnt <= 0; md_hi <= 32'h0; md_lo <= 32'h0;
         u_hi <= 32'h0; u_lo <= 32'h0;
      end else if (u_cnt != 0) begin
         u_cnt <= u_cnt - 1;
         if (u_cnt == 1) begin
            md_busy <= 1'b0; md_hi <= u_hi; md_lo <= u_lo;
         end
      end else if (md_start) begin
         if (md_ctrl >= 3'd1 && md_ctrl <= 3'd4) begin
            md_busy <= 1'b1;
            u_hi <= u_res[63:32];
            u_lo <= u_res[31:0];
            u_cnt <= stuck_req ? 20 : (md_ctrl <= 3'd2 ? 5 : 10);
         end else if (md_ctrl == 3'd5) md_hi <= md_A;
         else if (md_ctrl == 3'd6) md_lo <= md_A;
      end
   end

   // Reference model: EX is held for the cycle after an accept and whenever the unit is busy
   bit          e_start = 1'b0, e_to = 1'b0, inflight = 1'b0;
   logic [31:0] e_A = 32'h0, e_B = 32'h0, a_hi = 32'h0, a_lo = 32'h0;
   logic [2:0]  e_ctrl = 3'd0;
   bit          k_hi = 1'b1, k_lo = 1'b1;
   int          age = 0, busy_seen = 0;
   bit          hz, e_stall, acc;
   logic [31:0] e_mf;
   logic [64:0] a_res;

   always @(negedge clk) begin
      hz      = ex_valid && !flush && ex_op >= 4'd1 && ex_op <= 4'd8;
      e_stall = hz && (e_start || md_busy);
      e_mf    = (ex_op == 4'd7) ? md_hi : (ex_op == 4'd8) ? md_lo : 32'h0;
      if (chk_en) begin
         chk("stall", {31'h0, stall}, {31'h0, e_stall});
         chk("md_start", {31'h0, md_start}, {31'h0, e_start});
         chk("md_A", md_A, e_A);
         chk("md_B", md_B, e_B);
         chk("md_ctrl", {29'h0, md_ctrl}, {29'h0, e_ctrl});
         chk("md_timeout", {31'h0, md_timeout}, {31'h0, e_to});
         chk("mf_data", mf_data, e_mf);
         chk("start_while_busy", {31'h0, md_start & md_busy}, 32'h0);
         if (hz && !e_stall && ex_op == 4'd7 && k_hi) chk("mfhi_arch", mf_data, a_hi);
         if (hz && !e_stall && ex_op == 4'd8 && k_lo) chk("mflo_arch", mf_data, a_lo);
      end
      if (reset) begin
         e_start = 0; e_to = 0; inflight = 0; e_A = 0; e_B = 0; e_ctrl = 0;
         a_hi = 0; a_lo = 0; k_hi = 1; k_lo = 1; age = 0; busy_seen = 0;
      end else begin
         if (inflight) begin
            if (age >= 1) begin
               if (md_busy) begin
                  busy_seen++;
                  if (busy_seen == WATCHDOG) begin e_to = 1; inflight = 0; end
               end else inflight = 0;
            end
            age++;
         end
         acc = hz && !e_stall && ex_op <= 4'd6;
         e_start = acc;
         if (acc) begin
            e_A = ex_rs; e_B = ex_rt; e_ctrl = ex_op[2:0];
            if (ex_op <= 4'd4) begin
               a_res = md_result(ex_op[2:0], ex_rs, ex_rt);
               a_hi = a_res[63:32]; a_lo = a_res[31:0];
               k_hi = a_res[64]; k_lo = a_res[64];
               inflight = 1; age = 0; busy_seen = 0;
            end else if (ex_op == 4'd5) begin a_hi = ex_rs; k_hi = 1; end
            else begin a_lo = ex_rs; k_lo = 1; end
         end
      end
   end

   task automatic put(input bit v, input logic [3:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input bit fl);
      @(posedge clk); #1;
      reset = 1'b0; ex_valid = v; ex_op = op; ex_rs = rs; ex_rt = rt; flush = fl;
   endtask

   int starts, second_k;
   logic [3:0] rop;
   logic [31:0] rrt;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;

      // mult 7 * -3, then mflo / mfhi
      put(1, 4'd1, 32'd7, 32'hFFFF_FFFD, 0); @(negedge clk);
      chk("mult_T_stall", {31'h0, stall}, 32'h0);
      put(1, 4'd8, 0, 0, 0); @(negedge clk);
      chk("mult_T1_start", {31'h0, md_start}, 32'h1);
      chk("mult_T1_ctrl", {29'h0, md_ctrl}, 32'h1);
      chk("mult_T1_stall", {31'h0, stall}, 32'h1);
      for (int k = 2; k <= 6; k++) begin
         put(1, 4'd8, 0, 0, 0); @(negedge clk);
         chk("mult_busy_stall", {31'h0, stall}, 32'h1);
         chk("mult_single_start", {31'h0, md_start}, 32'h0);
      end
      put(1, 4'd8, 0, 0, 0); @(negedge clk);
      chk("mult_T7_stall", {31'h0, stall}, 32'h0);
      chk("mult_mflo", mf_data, 32'hFFFF_FFEB);
      put(1, 4'd7, 0, 0, 0); @(negedge clk);
      chk("mult_mfhi", mf_data, 32'hFFFF_FFFF);

      // divu 100 / 7
      put(1, 4'd4, 32'd100, 32'd7, 0);
      for (int k = 1; k <= 11; k++) begin
         put(1, 4'd7, 0, 0, 0); @(negedge clk);
         chk("divu_stall", {31'h0, stall}, 32'h1);
      end
      put(1, 4'd7, 0, 0, 0); @(negedge clk);
      chk("divu_T12_stall", {31'h0, stall}, 32'h0);
      chk("divu_mfhi", mf_data, 32'd2);
      put(1, 4'd8, 0, 0, 0); @(negedge clk);
      chk("divu_mflo", mf_data, 32'd14);

      // mthi then immediate mfhi
      put(1, 4'd5, 32'hDEAD_BEEF, 0, 0);
      put(1, 4'd7, 0, 0, 0); @(negedge clk);
      chk("mthi_stall1", {31'h0, stall}, 32'h1);
      put(1, 4'd7, 0, 0, 0); @(negedge clk);
      chk("mthi_stall2", {31'h0, stall}, 32'h0);
      chk("mthi_mfhi", mf_data, 32'hDEAD_BEEF);

      // flushed div is never issued
      put(1, 4'd3, 32'd50, 32'd5, 1); @(negedge clk);
      chk("flush_stall", {31'h0, stall}, 32'h0);
      put(0, 4'd0, 0, 0, 0); @(negedge clk);
      chk("flush_no_start", {31'h0, md_start}, 32'h0);
      put(1, 4'd7, 0, 0, 0); @(negedge clk);
      chk("flush_idle", {31'h0, stall}, 32'h0);

      // mult then multu back-to-back
      starts = 0; second_k = -1;
      for (int k = 0; k < 16; k++) begin
         if (k == 0) put(1, 4'd1, 32'd3, 32'd4, 0);
         else if (k <= 7) put(1, 4'd2, 32'd5, 32'd6, 0);
         else put(0, 4'd0, 0, 0, 0);
         @(negedge clk);
         if (md_start) begin
            starts++;
            if (starts == 2) second_k = k;
         end
         if (k == 6) chk("b2b_stall_k6", {31'h0, stall}, 32'h1);
         if (k == 7) chk("b2b_stall_k7", {31'h0, stall}, 32'h0);
      end
      chk("b2b_starts", starts, 32'd2);
      chk("b2b_second_start", second_k, 32'd8);

      // flush while BUSY does not cancel the op
      put(1, 4'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 0);
      for (int k = 1; k <= 7; k++) put(1, 4'd8, 0, 0, 1);
      put(1, 4'd8, 0, 0, 0); @(negedge clk);
      chk("flushbusy_stall", {31'h0, stall}, 32'h0);
      chk("flushbusy_mflo", mf_data, 32'd30);

      // unit held busy 20 cycles trips the watchdog
      stuck_req = 1'b1;
      put(1, 4'd1, 32'd2, 32'd3, 0);
      for (int k = 1; k <= 16; k++) put(0, 4'd0, 0, 0, 0);
      @(negedge clk);
      chk("wd_T16", {31'h0, md_timeout}, 32'h0);
      put(1, 4'd8, 0, 0, 0); @(negedge clk);
      chk("wd_T17", {31'h0, md_timeout}, 32'h1);
      chk("wd_T17_stall", {31'h0, stall}, 32'h1);
      for (int k = 18; k <= 21; k++) put(1, 4'd8, 0, 0, 0);
      stuck_req = 1'b0;
      put(1, 4'd8, 0, 0, 0); @(negedge clk);
      chk("wd_T22_stall", {31'h0, stall}, 32'h0);
      chk("wd_mflo", mf_data, 32'd6);

      // reset in the middle of a div
      put(1, 4'd3, 32'd1000, 32'd3, 0);
      for (int k = 0; k < 3; k++) put(0, 4'd0, 0, 0, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; ex_valid = 1'b1; ex_op = 4'd7;
      @(negedge clk);
      chk("rst_start", {31'h0, md_start}, 32'h0);
      chk("rst_A", md_A, 32'h0);
      chk("rst_B", md_B, 32'h0);
      chk("rst_ctrl", {29'h0, md_ctrl}, 32'h0);
      chk("rst_timeout", {31'h0, md_timeout}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            @(posedge clk); #1 reset = 1'b1;
         end else begin
            case ($urandom_range(0, 9))
               0:       rop = 4'd0;
               1:       rop = 4'($urandom_range(9, 15));
               default: rop = 4'($urandom_range(1, 8));
            endcase
            rrt = $urandom;
            if ($urandom_range(0, 3) == 0) rrt = 32'($urandom_range(0, 20));
            put($urandom_range(0, 9) != 0, rop, $urandom, rrt, $urandom_range(0, 9) == 0);
         end
      end
      for (int k = 0; k < 30; k++) put(0, 4'd0, 0, 0, 0);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
